uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 148 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits (LSB first), optional parity, 1 or 2 stop bits.
// The line is registered; the last stop cycle doubles as the tx_done/tx_ready cycle so held requests go back-to-back.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 uart_txd
);

    localparam int PAR_EFF  = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
    localparam int STOP_EFF = (STOP_BITS == 2) ? 2 : 1;
    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [3:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_nxt;
    logic                 txd_q, txd_nxt;
    logic                 done_q, done_nxt;
    logic                 bit_end;
    logic                 last_stop_end;

    // Handshake: a request transfers on a rising edge with tx_valid=1 and tx_ready=1; otherwise it is dropped.
    assign tx_ready = (state == IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = done_q;
    assign uart_txd = txd_q;

    assign bit_end       = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_stop_end = (idx == 4'(STOP_EFF - 1)) && (cnt == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_nxt;
            txd_q   <= txd_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        txd_nxt   = txd_q;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                txd_nxt = 1'b1;
                if (tx_valid) begin
                    state_nxt = START;
                    shreg_nxt = tx_data;
                    // Odd parity is the inverted XOR reduction of the payload.
                    par_nxt   = (^tx_data) ^ (PAR_EFF == 1);
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    txd_nxt   = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    shreg_nxt = shreg >> 1;
                    if (idx == 4'(DATA_BITS - 1)) begin
                        idx_nxt = '0;
                        if (PAR_EFF != 0) begin
                            state_nxt = PAR;
                            txd_nxt   = par_bit;
                        end else begin
                            state_nxt = STOP;
                            txd_nxt   = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx + 4'd1;
                        txd_nxt = shreg[1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    txd_nxt   = 1'b1;
                end
            end
            STOP: begin
                txd_nxt = 1'b1;
                // Leave one cycle early: the IDLE/done cycle is the final stop cycle on the line.
                if (last_stop_end) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (bit_end) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: several parameter sets side by side, a table of frames plus
// hand-written back-to-back and mid-frame reset sequences.
module tb_uart_tx_cfg;

    localparam int CPB = 4;
    localparam int NDUT = 5;

    logic            clk;
    logic            rst;
    logic [NDUT-1:0] valid;
    logic [8:0]      data [NDUT];
    logic [NDUT-1:0] ready, busy, done, txd;

    int checks;
    int errors;

    typedef struct {
        int         sel;
        logic [8:0] d;
        int         nb;
        logic [11:0] bits;  // bit i = i-th bit on the line, start bit at bit 0
        string      name;
    } vec_t;

    vec_t vecs [5];

    // 0: 8N1   1: 8E1   2: 8O1   3: 5N2   4: illegal PARITY/STOP_BITS (behaves as 8N1)
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]), .uart_txd(txd[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]), .uart_txd(txd[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
        .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]), .uart_txd(txd[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) dut_d (
        .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(data[3][4:0]),
        .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]), .uart_txd(txd[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(3), .STOP_BITS(3)) dut_e (
        .clk(clk), .rst(rst), .tx_valid(valid[4]), .tx_data(data[4][7:0]),
        .tx_ready(ready[4]), .tx_busy(busy[4]), .tx_done(done[4]), .uart_txd(txd[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic offer(input int sel, input logic [8:0] d);
        @(negedge clk);
        check("ready before offer", 64'(ready[sel]), 64'd1);
        valid[sel] = 1'b1;
        data[sel]  = d;
        @(posedge clk);
    endtask

    // Watches one frame from its first cycle; drives junk on the inputs meanwhile.
    task automatic run_frame(input int sel, input int nb, input logic [11:0] eb,
                             input bit hold, input logic [8:0] nd, input string name);
        logic [47:0] obs, expv;
        int done_cnt, done_pos, bad, len;
        len = nb * CPB;
        obs = '0; expv = '0; done_cnt = 0; done_pos = -1; bad = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            obs[k]  = txd[sel];
            expv[k] = eb[k / CPB];
            if (done[sel] === 1'b1) begin
                done_cnt++;
                done_pos = k;
            end
            if (k < len - 1 && busy[sel] !== 1'b1) bad++;
            if (k == len - 1 && ready[sel] !== 1'b1) bad++;
            if (k < len - 1) begin
                valid[sel] = hold ? 1'b1 : 1'($urandom_range(0, 1));
                data[sel]  = 9'($urandom_range(0, 511));
            end else begin
                valid[sel] = hold;
                data[sel]  = nd;
            end
        end
        check({name, " line"}, 64'(obs), 64'(expv));
        check({name, " done count"}, 64'(done_cnt), 64'd1);
        check({name, " done cycle"}, 64'(done_pos), 64'(len - 1));
        check({name, " busy/ready"}, 64'(bad), 64'd0);
        if (!hold) begin
            @(negedge clk);
            check({name, " idle after"}, 64'({ready[sel], busy[sel], done[sel], txd[sel]}), 64'b1001);
        end
    endtask

    initial begin
        int done_seen;
        checks = 0;
        errors = 0;
        vecs[0] = '{sel: 0, d: 9'h0A5, nb: 10, bits: 12'h34A, name: "8N1 A5"};
        vecs[1] = '{sel: 1, d: 9'h007, nb: 11, bits: 12'h60E, name: "8E1 07"};
        vecs[2] = '{sel: 2, d: 9'h007, nb: 11, bits: 12'h40E, name: "8O1 07"};
        vecs[3] = '{sel: 3, d: 9'h01F, nb: 8,  bits: 12'h0FE, name: "5N2 1F"};
        vecs[4] = '{sel: 4, d: 9'h0A5, nb: 10, bits: 12'h34A, name: "illegal cfg A5"};

        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < NDUT; i++) data[i] = '0;
        #1;
        check("reset ready", 64'(ready), 64'h1F);
        check("reset busy",  64'(busy),  64'h00);
        check("reset done",  64'(done),  64'h00);
        check("reset txd",   64'(txd),   64'h1F);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            offer(vecs[v].sel, vecs[v].d);
            run_frame(vecs[v].sel, vecs[v].nb, vecs[v].bits, 1'b0, 9'h000, vecs[v].name);
        end

        // Held request: second frame must start right after the first frame's last stop cycle.
        offer(0, 9'h055);
        run_frame(0, 10, 12'h2AA, 1'b1, 9'h0AA, "b2b first 55");
        run_frame(0, 10, 12'h354, 1'b0, 9'h000, "b2b second AA");

        // Reset during data bit 3 of 0xC3 (line bit 4, a 0), then a clean 0x3C frame.
        offer(0, 9'h0C3);
        done_seen = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            valid[0] = 1'b0;
            if (done[0] === 1'b1) done_seen++;
        end
        check("pre-reset data bit 3", 64'(txd[0]), 64'd0);
        rst = 1'b1;
        #1;
        check("mid-frame reset outputs", 64'({ready[0], busy[0], done[0], txd[0]}), 64'b1001);
        repeat (2) begin
            @(negedge clk);
            if (done[0] === 1'b1) done_seen++;
        end
        check("no done across reset", 64'(done_seen), 64'd0);
        rst      = 1'b0;
        valid[0] = 1'b1;
        data[0]  = 9'h03C;
        @(posedge clk);
        run_frame(0, 10, 12'h278, 1'b0, 9'h000, "after reset 3C");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
